// File: rtl/tx_request_arbiter.sv
// tx_request_arbiter: grants one of message / hard reset / cable reset to the PHY, with ack timeout, message retry and sticky alerts.
module tx_request_arbiter #(
  parameter int TIMEOUT_CYCLES = 10,
  parameter int N_RETRY = 3
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        iMsgReq,
  input  logic        iHardResetReq,
  input  logic        iCableResetReq,
  input  logic        PHY_ACK,
  input  logic        PHY_NACK,
  input  logic [15:0] iAlertClear,
  output logic        oTxStart,
  output logic [2:0]  oTxType,
  output logic [2:0]  oGrant,
  output logic        oBusy,
  output logic        oDone,
  output logic [15:0] oAlert
);
  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    ISSUE    = 5'b00010,
    WAIT_ACK = 5'b00100,
    RETRY    = 5'b01000,
    REPORT   = 5'b10000
  } state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(N_RETRY + 2);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] retry, retry_n;
  logic [2:0] grant_n, type_n, set_n;
  logic start_n, done_n, abort, fail;
  // a hard reset may only cut in on an in-flight message, never on a cable reset
  assign abort = oGrant[0] & iHardResetReq & (state == ISSUE || state == WAIT_ACK || state == RETRY);
  assign fail = PHY_NACK | (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign oBusy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    retry_n = retry;
    grant_n = oGrant;
    type_n = oTxType;
    done_n = 1'b0;
    set_n = 3'b000;
    start_n = state == ISSUE && !abort;
    if (abort) begin
      state_n = ISSUE;
      grant_n = 3'b010;
      type_n = 3'b101;
      retry_n = '0;
      done_n = 1'b1;
      set_n = 3'b010;
    end else case (state)
      IDLE: if (iHardResetReq | iCableResetReq | iMsgReq) begin
        state_n = ISSUE;
        grant_n = iHardResetReq ? 3'b010 : iCableResetReq ? 3'b100 : 3'b001;
        type_n = iHardResetReq ? 3'b101 : iCableResetReq ? 3'b110 : 3'b000;
      end
      ISSUE: begin
        cnt_n = '0;
        state_n = WAIT_ACK;
      end
      WAIT_ACK: begin
        cnt_n = cnt + 1'b1;
        if (PHY_ACK) begin
          state_n = REPORT;
          done_n = 1'b1;
          set_n = 3'b100;
        end else if (fail && oGrant[0] && retry < RW'(N_RETRY)) begin
          retry_n = retry + 1'b1;
          state_n = RETRY;
        end else if (fail) begin
          state_n = REPORT;
          done_n = 1'b1;
          set_n = 3'b001;
        end
      end
      RETRY: state_n = ISSUE;
      REPORT: begin
        state_n = IDLE;
        grant_n = '0;
        type_n = '0;
        retry_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  // done and alert are registered on entry to REPORT so PHY_ACK -> oDone is one cycle
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      retry <= '0;
      oGrant <= '0;
      oTxType <= '0;
      oTxStart <= 1'b0;
      oDone <= 1'b0;
      oAlert <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      retry <= retry_n;
      oGrant <= grant_n;
      oTxType <= type_n;
      oTxStart <= start_n;
      oDone <= done_n;
      oAlert <= (oAlert & ~iAlertClear) | {9'b0, set_n, 4'b0};
    end
  end
endmodule

// File: tb/tb_tx_request_arbiter.sv
// tb_tx_request_arbiter: randomized transactions checked against a per-transaction timeline model of the arbiter.
module tb_tx_request_arbiter;
  localparam int T = 10;
  localparam int NR = 3;
  logic CLK = 1'b0;
  logic reset = 1'b0;
  logic iMsgReq = 1'b0, iHardResetReq = 1'b0, iCableResetReq = 1'b0, PHY_ACK = 1'b0, PHY_NACK = 1'b0;
  logic [15:0] iAlertClear = '0;
  logic oTxStart, oBusy, oDone;
  logic [2:0] oTxType, oGrant;
  logic [15:0] oAlert;
  logic [15:0] exp_alert = '0;
  int checks = 0;
  int failures = 0;
  always #5 CLK = ~CLK;
  tx_request_arbiter #(.TIMEOUT_CYCLES(T), .N_RETRY(NR)) dut (
    .CLK(CLK), .reset(reset), .iMsgReq(iMsgReq), .iHardResetReq(iHardResetReq),
    .iCableResetReq(iCableResetReq), .PHY_ACK(PHY_ACK), .PHY_NACK(PHY_NACK),
    .iAlertClear(iAlertClear), .oTxStart(oTxStart), .oTxType(oTxType), .oGrant(oGrant),
    .oBusy(oBusy), .oDone(oDone), .oAlert(oAlert)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int idx(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return i;
    return -1;
  endfunction
  // kinds: 0 msg, 1 hard, 2 cable, 3 msg+hard, 4 msg+cable, 5 msg aborted by hard, 6 msg with late cable
  // fr: forced response (0 ack, 1 nack, 2 none, -1 random); fd: forced delay; fc: forced clear mask
  task automatic run_txn(input int kind, input int fr, input int fd, input int fc);
    int starts[$], pc[$], dones[$];
    logic [2:0] ty[$], gr[$];
    logic [15:0] al[$];
    bit pa[$];
    int s = 2, h = -1, cab = -1, fin, maxa, r = 0, d, e = 0;
    logic [2:0] t3, g3;
    logic [15:0] clr;
    bit hard = (kind == 1 || kind == 3);
    bit cable = (kind == 2 || kind == 4);
    bit msg = !hard && !cable;
    if (kind == 5) begin
      h = 1 + $urandom_range(0, 9);
      if (h >= 2) begin
        starts.push_back(2);
        ty.push_back(3'b000);
        gr.push_back(3'b001);
      end
      dones.push_back(h + 1);
      exp_alert |= 16'h0020;
      al.push_back(exp_alert);
      s = h + 2;
      hard = 1;
      msg = 0;
    end
    t3 = hard ? 3'b101 : cable ? 3'b110 : 3'b000;
    g3 = hard ? 3'b010 : cable ? 3'b100 : 3'b001;
    maxa = msg ? NR + 1 : 1;
    for (int a = 0; a < maxa; a++) begin
      starts.push_back(s);
      ty.push_back(t3);
      gr.push_back(g3);
      r = (fr >= 0) ? fr : $urandom_range(0, 2);
      d = (r == 2) ? T - 1 : (fd >= 0) ? fd : $urandom_range(0, T - 1);
      e = s + d;
      if (r != 2) begin
        pc.push_back(e);
        pa.push_back(r == 0);
      end
      if (r == 0 || a == maxa - 1) break;
      s = e + 3;
    end
    fin = e + 1;
    dones.push_back(fin);
    clr = (fc >= 0) ? 16'(fc) : ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0000;
    exp_alert = (exp_alert & ~clr) | ((r == 0) ? 16'h0040 : 16'h0010);
    al.push_back(exp_alert);
    if (kind == 6) cab = 1 + $urandom_range(0, fin - 2);
    for (int t = 0; t <= fin + 1; t++) begin
      int k;
      @(negedge CLK);
      k = idx(starts, t);
      chk("tx_start", oTxStart, k >= 0);
      if (k >= 0) begin
        chk("tx_type", oTxType, ty[k]);
        chk("grant", oGrant, gr[k]);
      end
      k = idx(dones, t);
      chk("done", oDone, k >= 0);
      if (k >= 0) chk("alert", oAlert, al[k]);
      if (t == 1) chk("busy", oBusy, 1);
      if (t == fin + 1) chk("idle", {oBusy, oGrant, oTxType}, 0);
      iMsgReq = (kind == 0 || kind >= 3) && t < ((kind == 5) ? h + 1 : fin);
      iHardResetReq = ((kind == 1 || kind == 3) || (kind == 5 && t >= h)) && t < fin;
      iCableResetReq = ((kind == 2 || kind == 4) || (kind == 6 && t >= cab)) && t < fin;
      k = idx(pc, t);
      PHY_ACK = k >= 0 && pa[k];
      PHY_NACK = k >= 0 && !pa[k];
      iAlertClear = (t == fin - 1) ? clr : 16'h0000;
    end
  endtask
  task automatic idle_gap();
    int n = $urandom_range(0, 3);
    logic [15:0] clr;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk("gap_alert", oAlert, exp_alert);
      clr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
      iAlertClear = clr;
      exp_alert &= ~clr;
    end
    @(negedge CLK);
    chk("gap_alert", oAlert, exp_alert);
    iAlertClear = '0;
  endtask
  task automatic reset_mid();
    @(negedge CLK);
    iMsgReq = 1;
    repeat (5) @(negedge CLK);
    chk("pre_reset_busy", oBusy, 1);
    reset = 0;
    iMsgReq = 0;
    @(negedge CLK);
    chk("reset_outs", {oTxStart, oTxType, oGrant, oBusy, oDone, oAlert}, 0);
    reset = 1;
    exp_alert = '0;
    repeat (15) begin
      @(negedge CLK);
      chk("no_done_after_reset", oDone, 0);
    end
  endtask
  initial begin
    repeat (2) @(negedge CLK);
    chk("init_outs", {oTxStart, oTxType, oGrant, oBusy, oDone, oAlert}, 0);
    reset = 1;
    @(negedge CLK);
    run_txn(0, 0, 4, 0);
    idle_gap();
    run_txn(0, 2, 0, 0);
    idle_gap();
    run_txn(3, 1, 2, 0);
    idle_gap();
    run_txn(5, 0, 3, 16'h0050);
    idle_gap();
    run_txn(0, 0, T - 1, 16'h0040);
    idle_gap();
    run_txn(6, 0, 5, -1);
    idle_gap();
    for (int i = 0; i < 40; i++) begin
      run_txn($urandom_range(0, 6), -1, -1, -1);
      idle_gap();
    end
    reset_mid();
    run_txn(0, -1, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
